// File: rtl/ram_banked_sync_if.sv
// Request/response bus for ram_banked_sync: one request latch in, one
// registered response pulse out. chip_enable travels with the request side.
interface ram_banked_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    chip_enable;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_address;
  logic [DATA_WIDTH-1:0]   req_write_data;
  logic [DATA_WIDTH/8-1:0] req_write_select;
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   resp_read_data;
  logic                    resp_error;

  modport master (
    output chip_enable, req_valid, req_write, req_address,
           req_write_data, req_write_select,
    input  req_ready, resp_valid, resp_read_data, resp_error
  );

  modport slave (
    input  chip_enable, req_valid, req_write, req_address,
           req_write_data, req_write_select,
    output req_ready, resp_valid, resp_read_data, resp_error
  );
endinterface

// File: rtl/ram_banked_sync.sv
// Synchronous data memory with a single-entry request latch, programmable
// wait states, byte-granular writes and a registered one-cycle response.
module ram_banked_sync #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic             clock,
  input  logic             reset,
  ram_banked_sync_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int HI    = DEPTH_LOG2 + LSB;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [NB-1:0]           sel_q, sel_d;
  logic                    err_q, err_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_error_q, resp_error_d;
  logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic                    mem_we;
  logic                    misaligned;
  logic                    out_of_range;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign misaligned = |bus.req_address[LSB-1:0];

  // Any address bit above the word index makes the request out of range.
  generate
    if (ADDR_WIDTH > HI) begin : g_oor
      assign out_of_range = |bus.req_address[ADDR_WIDTH-1:HI];
    end else begin : g_no_oor
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign bus.req_ready      = (state_q == S_IDLE) && bus.chip_enable;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.resp_read_data = resp_data_q;

  // Next-state logic: accept into the latch, count wait states, commit.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    idx_d        = idx_q;
    data_d       = data_q;
    sel_d        = sel_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_data_d  = '0;
    mem_we       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.chip_enable && bus.req_valid) begin
          wr_d    = bus.req_write;
          idx_d   = bus.req_address[HI-1:LSB];
          data_d  = bus.req_write_data;
          sel_d   = bus.req_write_select;
          err_d   = misaligned || out_of_range;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_valid_d = 1'b1;
          resp_error_d = err_q;
          mem_we       = wr_q && !err_q;
          if (!wr_q && !err_q) begin
            resp_data_d = mem[idx_q];
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers; reset abandons any in-flight access.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      idx_q        <= '0;
      data_q       <= '0;
      sel_q        <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Storage: byte-masked write at commit; not cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (sel_q[i]) begin
          mem[idx_q][8*i +: 8] <= data_q[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: doc/ram_banked_sync.md
# ram_banked_sync

Parametrised synchronous data memory for the MIPS core's memory stage. It supersedes the fixed 1024×32 combinational-read memory with configurable width, depth and wait states. Each access is a request/response transaction: a single-entry request latch, a programmable wait-state counter, byte-granular writes and a registered read response. Out-of-range and misaligned addresses are rejected with an error flag.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8, ≥ 16
- ADDR_WIDTH, 32, byte-address width
- DEPTH_LOG2, 10, log2 of word count
- WAIT_STATES, 0, extra cycles before an access commits (0..15)

- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- chip_enable  input  1  block enable; low blocks new requests
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = write, 0 = read
- req_address  input  ADDR_WIDTH  byte address
- req_write_data  input  DATA_WIDTH  write data
- req_write_select  input  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i]
- resp_valid  output  1  one-cycle response pulse
- resp_read_data  output  DATA_WIDTH  read data; 0 for writes and errors
- resp_error  output  1  valid with resp_valid; request rejected

## Operation
- LSB = log2(DATA_WIDTH/8). Word index = req_address[DEPTH_LOG2+LSB-1:LSB].
- Misaligned: req_address[LSB-1:0] ≠ 0. Out of range: any req_address bit above DEPTH_LOG2+LSB-1 is set. Either condition sets the error flag.
- Storage: 2^DEPTH_LOG2 words. Reset does not clear storage.
- States:
  - IDLE: req_ready = chip_enable.
  - BUSY: req_ready = 0.
- Accept when the state is IDLE, chip_enable = 1 and req_valid = 1 at an edge. At that edge:
  - latch write flag, word index, data, byte selects and error flag;
  - load the counter with WAIT_STATES;
  - go to BUSY.
- BUSY, counter ≠ 0: decrement the counter each edge.
- BUSY, counter = 0, at the commit edge:
  - write without error: update only the bytes whose select bit is 1. All-zero select is a legal no-op write.
  - read without error: resp_read_data ← storage word.
  - error: no storage change, resp_read_data ← 0, resp_error ← 1.
  - any write: resp_read_data ← 0.
  - resp_valid ← 1; go to IDLE.
- resp_valid, resp_error and resp_read_data hold for exactly one cycle. They clear at the next edge unless another commit occurs.
- chip_enable is sampled only at acceptance. Dropping it while BUSY does not abort the transaction.
- Inputs other than req_valid/chip_enable are don't-care outside the accept edge.

## Timing
- Reset values: state IDLE, counter 0, resp_valid 0, resp_error 0, resp_read_data 0. req_ready equals chip_enable after reset.
- Reset asserted while BUSY: the transaction is abandoned, no write is performed and no response is produced.
- Accept at edge E0; commit at edge E0+WAIT_STATES+1.
- resp_valid is high in the cycle after the commit edge. Latency is WAIT_STATES+1 cycles.
- req_ready is high again in the same cycle as resp_valid. The next accept is at E0+WAIT_STATES+2, giving a peak rate of 1 request per WAIT_STATES+2 cycles.
- Read after write: a read accepted after a write's response returns the new data. No hazard exists because transactions never overlap.
- There is no resp_ready: the consumer must take the response in its valid cycle.

## Test plan
- Reset, then WAIT_STATES=0: write 0xDEADBEEF, select 4'hF, address 0x10 accepted at E0. resp_valid at E1+ with data 0, error 0. Read at 0x10 returns 0xDEADBEEF.
- Partial write: select 4'b0101, data 0x11223344 at 0x10 over 0xDEADBEEF. Read returns 0xDE22BE44. All-zero select leaves the word unchanged.
- WAIT_STATES=3: req_ready stays low for 4 cycles after accept and resp_valid appears 4 cycles after accept. req_valid held continuously gives one accept per 5 cycles.
- Errors:
  - read at 0x12: resp_error 1, data 0;
  - write at 0x1000 (DEPTH_LOG2=10, 32-bit words): resp_error 1, and address 0x0 is unchanged.
- chip_enable=0 with req_valid=1 gives no accept and req_ready 0. Dropping chip_enable mid-BUSY still produces the response.
- Reset asserted one cycle after a write is accepted, with WAIT_STATES=2: no resp_valid, target word unchanged, block in IDLE with all outputs 0.
